// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin arbiter granting a shared down-counting interval timer
// Optional pause input enabled by defining TIMER_ARBITER_PAUSE_EN.
module timer_arbiter #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] len,
`ifdef TIMER_ARBITER_PAUSE_EN
    input  logic           pause,
`endif
    output logic [R-1:0]   gnt,
    output logic [R-1:0]   done,
    output logic           busy,
    output logic [N-1:0]   cnt
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] last;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] pos;
    logic          win_found;
    logic [N-1:0]  len_sel;
    logic [N-1:0]  len_cap;
    logic          hold;

`ifdef TIMER_ARBITER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Round-robin search starting just after the last completed requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int k = 1; k <= R; k++) begin
            pos = IW'((int'(last) + k) % R);
            if (!win_found && req[pos]) begin
                win_found = 1'b1;
                win_idx   = pos;
            end
        end
    end

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < R; i++) begin
            if (IW'(i) == win_idx) begin
                len_sel = len[i*N +: N];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (win_found) state_nxt = LOAD;
            LOAD: state_nxt = RUN;
            RUN:  if (!hold && cnt == '0) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            len_cap <= '0;
            cnt     <= '0;
            last    <= IW'(R - 1);
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        gnt     <= R'(1) << win_idx;
                        gnt_idx <= win_idx;
                        len_cap <= len_sel;
                    end
                end
                LOAD: cnt <= len_cap;
                RUN: begin
                    if (!hold && cnt != '0) begin
                        cnt <= cnt - N'(1);
                    end
                end
                DONE: begin
                    gnt  <= '0;
                    last <= gnt_idx;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE) ? gnt : '0;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - randomized and directed bench for timer_arbiter against a grant-timeline model
module tb_timer_arbiter;

    localparam int N = 8;
    localparam int R = 4;

    logic           clk;
    logic           rst;
    logic [R-1:0]   req;
    logic [R*N-1:0] len;
    logic           pause_i;
    logic [R-1:0]   gnt;
    logic [R-1:0]   done;
    logic           busy;
    logic [N-1:0]   cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a grant is a timeline measured in effective cycles since the grant edge.
    int m_active;
    int m_e;
    int m_len;
    int m_idx;
    int m_last;

    timer_arbiter #(.N(N), .R(R)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .len  (len),
`ifdef TIMER_ARBITER_PAUSE_EN
        .pause(pause_i),
`endif
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .cnt  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_e      = 0;
        m_len    = 0;
        m_idx    = 0;
        m_last   = R - 1;
    endtask

    task automatic model_edge(input logic [R-1:0] r, input logic [R*N-1:0] l, input logic p);
        int i;
        if (m_active == 0) begin
            for (int k = 1; k <= R; k++) begin
                i = (m_last + k) % R;
                if (m_active == 0 && r[i]) begin
                    m_active = 1;
                    m_idx    = i;
                end
            end
            if (m_active != 0) begin
                m_e   = 0;
                m_len = int'(l[m_idx*N +: N]);
            end
        end else begin
            if (!(p && m_e >= 1 && m_e <= m_len + 1)) m_e++;
            if (m_e == m_len + 3) begin
                m_active = 0;
                m_last   = m_idx;
            end
        end
    endtask

    task automatic check_outputs();
        logic [R-1:0] eg;
        int ec;
        eg = '0;
        if (m_active != 0) eg[m_idx] = 1'b1;
        ec = (m_active != 0 && m_e >= 1 && m_e <= m_len + 1) ? m_len - (m_e - 1) : 0;
        check("gnt", 32'(gnt), 32'(eg));
        check("done", 32'(done), (m_active != 0 && m_e == m_len + 2) ? 32'(eg) : 32'd0);
        check("busy", 32'(busy), (m_active != 0) ? 32'd1 : 32'd0);
        check("cnt", 32'(cnt), 32'(ec));
    endtask

    task automatic step(input logic [R-1:0] r, input logic [R*N-1:0] l, input logic p);
        req     = r;
        len     = l;
        pause_i = p;
        @(posedge clk);
        #1;
        model_edge(r, l, p);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_latency(input int idx, input int l, output int lat);
        logic [R*N-1:0] lv;
        logic [R-1:0]   r;
        lv = '0;
        lv[idx*N +: N] = N'(l);
        r = '0;
        r[idx] = 1'b1;
        step(r, lv, 1'b0);
        lat = 0;
        do begin
            step('0, lv, 1'b0);
            lat++;
        end while (done == '0 && lat < 600);
        step('0, lv, 1'b0);
    endtask

    initial begin
        logic [R*N-1:0] lv;
        logic [R*N-1:0] lv2;
        logic [R-1:0]   r;
        logic [R-1:0]   prev;
        logic [R-1:0]   exp_rr [5];
        logic           p;
        int             lat;
        int             got;

        rst = 1'b1;
        req = '0;
        len = '0;
        pause_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        step('0, '0, 1'b0);
        step('0, '0, 1'b0);

        // Single request, len 3
        lv = '0;
        lv[0 +: N] = N'(3);
        step(4'b0001, lv, 1'b0);
        check("d1_gnt", 32'(gnt), 32'h1);
        for (int k = 1; k <= 5; k++) begin
            step('0, lv, 1'b0);
            if (k <= 4) check("d1_cnt", 32'(cnt), 32'(4 - k));
        end
        check("d1_done", 32'(done), 32'h1);
        step('0, lv, 1'b0);
        check("d1_busy", 32'(busy), 32'h0);

        // Latency extremes
        run_latency(1, 0, lat);
        check("lat_len0", 32'(lat), 32'd2);
        run_latency(2, 255, lat);
        check("lat_len255", 32'(lat), 32'd257);

        // Round-robin order with all requesters held
        do_reset();
        exp_rr[0] = 4'b0001;
        exp_rr[1] = 4'b0010;
        exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000;
        exp_rr[4] = 4'b0001;
        lv = '0;
        for (int i = 0; i < R; i++) lv[i*N +: N] = N'(1);
        got  = 0;
        prev = '0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            step('1, lv, 1'b0);
            if (gnt != '0 && prev == '0) begin
                check("rr_order", 32'(gnt), 32'(exp_rr[got]));
                got++;
            end
            prev = gnt;
        end
        check("rr_count", 32'(got), 32'd5);
        for (int c = 0; c < 6; c++) step('0, lv, 1'b0);

        // Asynchronous reset mid-run
        do_reset();
        lv = '0;
        lv[0 +: N] = N'(8);
        step(4'b0001, lv, 1'b0);
        for (int c = 0; c < 4; c++) step('0, lv, 1'b0);
        check("rc_cnt5", 32'(cnt), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check("rc_no_done", 32'(done), 32'h0);
        check("rc_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        lv = '0;
        lv[2*N +: N] = N'(2);
        step(4'b0100, lv, 1'b0);
        check("rc_prio", 32'(gnt), 32'h4);
        for (int c = 0; c < 6; c++) step('0, lv, 1'b0);

        // Changes after capture are ignored
        lv = '0;
        lv[0 +: N] = N'(4);
        step(4'b0001, lv, 1'b0);
        check("cap_gnt", 32'(gnt), 32'h1);
        lv2 = '0;
        lv2[0 +: N] = N'(9);
        lat = 0;
        do begin
            step('0, lv2, 1'b0);
            lat++;
        end while (done == '0 && lat < 50);
        check("cap_lat", 32'(lat), 32'd6);
        check("cap_done", 32'(done), 32'h1);
        step('0, lv2, 1'b0);

`ifdef TIMER_ARBITER_PAUSE_EN
        lv = '0;
        lv[0 +: N] = N'(4);
        step(4'b0001, lv, 1'b0);
        lat = 0;
        do begin
            step('0, lv, 1'b0);
            lat++;
        end while (cnt != N'(2) && lat < 50);
        for (int c = 0; c < 3; c++) begin
            step('0, lv, 1'b1);
            lat++;
            check("pause_cnt", 32'(cnt), 32'd2);
        end
        do begin
            step('0, lv, 1'b0);
            lat++;
        end while (done == '0 && lat < 50);
        check("pause_lat", 32'(lat), 32'd9);
        step('0, lv, 1'b0);
`endif

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            r = R'($urandom);
            if ($urandom % 4 == 0) r = '0;
            for (int i = 0; i < R; i++) begin
                lv[i*N +: N] = ($urandom % 16 == 0) ? N'($urandom) : N'($urandom % 6);
            end
            p = 1'b0;
`ifdef TIMER_ARBITER_PAUSE_EN
            p = ($urandom % 4 == 0);
`endif
            step(r, lv, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have parameter N, default 8: width of the shared interval counter and of each length field.
REQ-002 SHALL have parameter R, default 4: number of requesters (R >= 2).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  R  per-requester level request; bit i = requester i.
REQ-006 SHALL have port len  input  R*N  packed interval lengths; requester i at bits [i*N +: N].
REQ-007 SHALL have port gnt  output  R  one-hot grant; all-zero when idle.
REQ-008 SHALL have port done  output  R  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port cnt  output  N  current value of the shared counter.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, RUN, DONE; transitions: IDLE->LOAD when any req bit is high; LOAD->RUN unconditionally; RUN->DONE when cnt==0; DONE->IDLE unconditionally.
REQ-012 SHALL arbitrate only in IDLE, round-robin: search starts at index (last granted + 1) mod R and wraps, so the first high req bit found wins.
REQ-013 SHALL register gnt one-hot and capture the winner's len field on the IDLE->LOAD edge; gnt stays constant through LOAD, RUN and DONE.
REQ-014 SHALL load the captured length into the counter on the LOAD->RUN edge.
REQ-015 SHALL decrement the counter by 1 on each RUN cycle in which cnt!=0, with no wrap below 0.
REQ-016 SHALL assert done[i] only in the DONE cycle, only for the granted index i, and for exactly one cycle.
REQ-017 SHALL clear gnt and update the last-granted pointer to the completed index on the DONE->IDLE edge.
REQ-018 SHALL produce latency from gnt rising to done pulse of len+2 cycles, giving 2 cycles for len=0 and 2^N+1 cycles for len=2^N-1.
REQ-019 SHALL leave cnt at 0 in DONE and IDLE.
REQ-020 SHALL spend at least one IDLE cycle between consecutive grants.
REQ-021 SHALL run each grant to completion (non-abortable): changes to req or len after capture have no effect.
REQ-022 SHALL give no priority to the requester whose done just pulsed; a req still high at the IDLE sample is treated as a new request.
REQ-023 SHALL keep busy=0 and gnt=0 with the FSM in IDLE while req is all-zero.

Reset
REQ-024 SHALL, on rst high at any time including mid-RUN, immediately force state=IDLE, gnt=0, done=0, busy=0, cnt=0 and last-granted pointer=R-1 (so requester 0 has first priority).
REQ-025 SHALL issue no done pulse for a grant aborted by reset.
REQ-026 SHALL evaluate the first arbitration on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, when macro TIMER_ARBITER_PAUSE_EN is defined, add input port pause (1 bit); while pause=1 in RUN, cnt and state hold, and pause has no effect in other states.
REQ-028 SHALL, when TIMER_ARBITER_PAUSE_EN is undefined, have no pause port, and the counter decrements every RUN cycle per REQ-015.

Verification
REQ-029 SHALL cover: reset, then req=0001, len0=3 -> gnt=0001 one cycle later; cnt sequence 3,2,1,0; done=0001 exactly 5 cycles after gnt rise; busy low afterward.
REQ-030 SHALL cover: req=1111 held, all len=1 -> grants in order 0001,0010,0100,1000,0001, each separated by one IDLE cycle.
REQ-031 SHALL cover: len=0 -> done 2 cycles after gnt; len=255 (N=8) -> done 257 cycles after gnt.
REQ-032 SHALL cover: rst pulse at cnt=5 mid-RUN -> gnt=0, cnt=0, busy=0 asynchronously, no done pulse; next req=0100 granted per reset priority.
REQ-033 SHALL cover: req0 dropped and len0 changed to 9 during RUN with len0=4 captured -> run completes with 4, done=0001 still pulses.
REQ-034 SHALL cover, with TIMER_ARBITER_PAUSE_EN defined: pause=1 for 3 cycles at cnt=2 -> cnt holds at 2, and done is delayed by exactly 3 cycles.
